// File: rtl/trigger_sequencer.sv
// Multi-stage sequential trigger on the logic-analyser sample path.
// Samples pass through one register stage and are tagged with arm/trigger/end events.
module trigger_sequencer #(
  parameter int BDW = 32,
  parameter int BAW = 6,
  parameter int SDW = 32,
  parameter int TSN = 4,
  parameter int TCW = 16,
  parameter int TSW = (TSN > 1) ? $clog2(TSN) : 1
) (
  input  logic           clk,
  input  logic           rst,
  output logic           bus_wready,
  input  logic           bus_wvalid,
  input  logic [BAW-1:0] bus_waddr,
  input  logic [BDW-1:0] bus_wdata,
  output logic           sti_tready,
  input  logic           sti_tvalid,
  input  logic [SDW-1:0] sti_tdata,
  input  logic           sto_tready,
  output logic           sto_tvalid,
  output logic [1:0]     sto_tevent,
  output logic [SDW-1:0] sto_tdata,
  output logic [1:0]     sts_state,
  output logic [TSW-1:0] sts_stage
);

  // state | meaning
  // IDLE  | not armed, no tagging
  // ARMED | walking the stage table
  // POST  | triggered, counting post-trigger samples
  // DONE  | capture finished, waiting for rearm
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_POST  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] EV_NONE = 2'b00;
  localparam logic [1:0] EV_ARM  = 2'b01;
  localparam logic [1:0] EV_TRIG = 2'b10;
  localparam logic [1:0] EV_END  = 2'b11;

  localparam int SIW = BAW - 3;
  localparam logic [TCW-1:0] CNT_MAX = '1;

  logic [SDW-1:0] val  [TSN];
  logic [SDW-1:0] msk  [TSN];
  logic [TCW-1:0] cnt  [TSN];
  logic           cons [TSN];
  logic [TCW-1:0] post;
  logic [TSW-1:0] last;

  logic [1:0]     state;
  logic [TSW-1:0] stage;
  logic [TCW-1:0] occ;
  logic [TCW-1:0] pcnt;
  logic           pend;

  logic           xfer;
  logic           wr_glob;
  logic           wr_stage;
  logic [SIW-1:0] widx;
  logic           cmd_arm;
  logic           cmd_abort;

  assign bus_wready = 1'b1;
  assign sti_tready = !sto_tvalid | sto_tready;
  assign xfer       = sti_tvalid & sti_tready;
  assign sts_state  = state;
  assign sts_stage  = stage;

  assign wr_glob   = bus_wvalid & ~bus_waddr[BAW-1];
  assign wr_stage  = bus_wvalid &  bus_waddr[BAW-1];
  assign widx      = bus_waddr[BAW-2:2];
  assign cmd_abort = wr_glob & (bus_waddr[BAW-2:0] == '0) & bus_wdata[1];
  assign cmd_arm   = wr_glob & (bus_waddr[BAW-2:0] == '0) & bus_wdata[0];

  logic [SDW-1:0] s_val;
  logic [SDW-1:0] s_msk;
  logic [TCW-1:0] s_cnt;
  logic           s_cons;
  logic           hit;
  logic [TCW-1:0] eff;
  logic [TCW-1:0] occ_inc;
  logic [TCW-1:0] pcnt_inc;
  logic [TSW-1:0] last_eff;

  logic [1:0]     state_n;
  logic [TSW-1:0] stage_n;
  logic [TCW-1:0] occ_n;
  logic [TCW-1:0] pcnt_n;
  logic           pend_n;
  logic [1:0]     ev;

  always_comb begin
    s_val    = val[stage];
    s_msk    = msk[stage];
    s_cnt    = cnt[stage];
    s_cons   = cons[stage];
    hit      = ((sti_tdata ^ s_val) & s_msk) == '0;
    eff      = (s_cnt == '0) ? TCW'(1) : s_cnt;
    occ_inc  = (occ == CNT_MAX) ? occ : occ + TCW'(1);
    pcnt_inc = (pcnt == CNT_MAX) ? pcnt : pcnt + TCW'(1);
    last_eff = (int'(last) >= TSN) ? TSW'(TSN - 1) : last;

    state_n = state;
    stage_n = stage;
    occ_n   = occ;
    pcnt_n  = pcnt;
    pend_n  = pend;
    ev      = EV_NONE;

    case (state)
      ST_ARMED: begin
        if (pend) begin
          ev     = EV_ARM;
          pend_n = 1'b0;
        end
        if (hit) begin
          if (occ_inc == eff) begin
            occ_n = '0;
            if (stage == last_eff) begin
              ev      = EV_TRIG;
              state_n = (post == '0) ? ST_DONE : ST_POST;
            end else begin
              stage_n = stage + TSW'(1);
            end
          end else begin
            occ_n = occ_inc;
          end
        end else if (s_cons) begin
          occ_n = '0;
        end
      end
      ST_POST: begin
        pcnt_n = pcnt_inc;
        if (pcnt_inc == post) begin
          ev      = EV_END;
          state_n = ST_DONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TSN; i++) begin
        val[i]  <= '0;
        msk[i]  <= '0;
        cnt[i]  <= '0;
        cons[i] <= 1'b0;
      end
      post <= '0;
      last <= TSW'(TSN - 1);
    end else begin
      if (wr_glob && bus_waddr[BAW-2:0] == (BAW-1)'(1))
        post <= bus_wdata[TCW-1:0];
      if (wr_glob && bus_waddr[BAW-2:0] == (BAW-1)'(2))
        last <= bus_wdata[TSW-1:0];
      for (int i = 0; i < TSN; i++) begin
        if (wr_stage && widx == SIW'(i)) begin
          case (bus_waddr[1:0])
            2'd0: val[i] <= bus_wdata[SDW-1:0];
            2'd1: msk[i] <= bus_wdata[SDW-1:0];
            2'd2: begin
              cnt[i]  <= bus_wdata[TCW-1:0];
              cons[i] <= bus_wdata[TCW];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // A control command in the same cycle as a transfer takes the FSM;
  // that sample passes untagged and the arm tag lands on the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sto_tvalid <= 1'b0;
      sto_tevent <= EV_NONE;
      sto_tdata  <= '0;
      state      <= ST_IDLE;
      stage      <= '0;
      occ        <= '0;
      pcnt       <= '0;
      pend       <= 1'b0;
    end else begin
      if (xfer) begin
        sto_tvalid <= 1'b1;
        sto_tdata  <= sti_tdata;
        sto_tevent <= (cmd_arm | cmd_abort) ? EV_NONE : ev;
      end else if (sto_tready) begin
        sto_tvalid <= 1'b0;
      end

      if (cmd_abort) begin
        state <= ST_IDLE;
        stage <= '0;
        occ   <= '0;
        pcnt  <= '0;
        pend  <= 1'b0;
      end else if (cmd_arm) begin
        state <= ST_ARMED;
        stage <= '0;
        occ   <= '0;
        pcnt  <= '0;
        pend  <= 1'b1;
      end else if (xfer) begin
        state <= state_n;
        stage <= stage_n;
        occ   <= occ_n;
        pcnt  <= pcnt_n;
        pend  <= pend_n;
      end
    end
  end

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer: table of per-sample expectations
// plus hand-written sequences for backpressure and arm/abort corners.
module tb_trigger_sequencer;

  localparam int BDW = 32;
  localparam int BAW = 6;
  localparam int SDW = 32;
  localparam int TSN = 4;
  localparam int TCW = 16;
  localparam int TSW = 2;

  logic           clk;
  logic           rst;
  logic           bus_wready;
  logic           bus_wvalid;
  logic [BAW-1:0] bus_waddr;
  logic [BDW-1:0] bus_wdata;
  logic           sti_tready;
  logic           sti_tvalid;
  logic [SDW-1:0] sti_tdata;
  logic           sto_tready;
  logic           sto_tvalid;
  logic [1:0]     sto_tevent;
  logic [SDW-1:0] sto_tdata;
  logic [1:0]     sts_state;
  logic [TSW-1:0] sts_stage;

  trigger_sequencer #(
    .BDW(BDW), .BAW(BAW), .SDW(SDW), .TSN(TSN), .TCW(TCW), .TSW(TSW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus_wready(bus_wready),
    .bus_wvalid(bus_wvalid),
    .bus_waddr(bus_waddr),
    .bus_wdata(bus_wdata),
    .sti_tready(sti_tready),
    .sti_tvalid(sti_tvalid),
    .sti_tdata(sti_tdata),
    .sto_tready(sto_tready),
    .sto_tvalid(sto_tvalid),
    .sto_tevent(sto_tevent),
    .sto_tdata(sto_tdata),
    .sts_state(sts_state),
    .sts_stage(sts_stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          tid;
    logic [31:0] d;
    logic [1:0]  ev;
    logic [1:0]  st;
    logic [1:0]  stg;
  } vec_t;

  vec_t vt[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic bus_wr(input logic [BAW-1:0] a, input logic [BDW-1:0] d);
    @(negedge clk);
    bus_wvalid = 1'b1;
    bus_waddr  = a;
    bus_wdata  = d;
    @(posedge clk);
    #1;
    bus_wvalid = 1'b0;
  endtask

  task automatic send(input logic [31:0] d);
    @(negedge clk);
    sti_tvalid = 1'b1;
    sti_tdata  = d;
    sto_tready = 1'b1;
    @(posedge clk);
    #1;
    sti_tvalid = 1'b0;
  endtask

  task automatic run_table(input int tid);
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].tid == tid) begin
        send(vt[i].d);
        chk($sformatf("t%0d[%0d] valid", tid, i), 32'(sto_tvalid), 32'd1);
        chk($sformatf("t%0d[%0d] data", tid, i), sto_tdata, vt[i].d);
        chk($sformatf("t%0d[%0d] event", tid, i), 32'(sto_tevent), 32'(vt[i].ev));
        chk($sformatf("t%0d[%0d] state", tid, i), 32'(sts_state), 32'(vt[i].st));
        chk($sformatf("t%0d[%0d] stage", tid, i), 32'(sts_stage), 32'(vt[i].stg));
      end
    end
  endtask

  function automatic logic [BAW-1:0] saddr(input int s, input int f);
    return BAW'(32 + s * 4 + f);
  endfunction

  initial begin
    vt.push_back('{1, 32'h0000_1234, 2'b00, 2'd0, 2'd0});
    vt.push_back('{1, 32'hDEAD_BEEF, 2'b00, 2'd0, 2'd0});
    vt.push_back('{1, 32'h0000_0007, 2'b00, 2'd0, 2'd0});
    vt.push_back('{2, 32'hA5, 2'b01, 2'd1, 2'd0});
    vt.push_back('{2, 32'h00, 2'b00, 2'd1, 2'd0});
    vt.push_back('{2, 32'hA5, 2'b10, 2'd2, 2'd0});
    vt.push_back('{2, 32'h11, 2'b00, 2'd2, 2'd0});
    vt.push_back('{2, 32'h22, 2'b11, 2'd3, 2'd0});
    vt.push_back('{2, 32'h33, 2'b00, 2'd3, 2'd0});
    vt.push_back('{3, 32'hA5, 2'b01, 2'd1, 2'd0});
    vt.push_back('{3, 32'h00, 2'b00, 2'd1, 2'd0});
    vt.push_back('{3, 32'hA5, 2'b00, 2'd1, 2'd0});
    vt.push_back('{3, 32'hA5, 2'b10, 2'd2, 2'd0});
    vt.push_back('{4, 32'h02, 2'b01, 2'd1, 2'd0});
    vt.push_back('{4, 32'h01, 2'b00, 2'd1, 2'd1});
    vt.push_back('{4, 32'h02, 2'b10, 2'd3, 2'd1});

    rst        = 1'b1;
    bus_wvalid = 1'b0;
    bus_waddr  = '0;
    bus_wdata  = '0;
    sti_tvalid = 1'b0;
    sti_tdata  = '0;
    sto_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;

    chk("reset tvalid", 32'(sto_tvalid), 32'd0);
    chk("reset tevent", 32'(sto_tevent), 32'd0);
    chk("reset tdata", sto_tdata, 32'd0);
    chk("reset state", 32'(sts_state), 32'd0);
    chk("reset stage", 32'(sts_stage), 32'd0);
    chk("reset sti_tready", 32'(sti_tready), 32'd1);
    chk("bus_wready", 32'(bus_wready), 32'd1);

    // 1: plain pass-through in IDLE, then drain
    run_table(1);
    @(negedge clk);
    sto_tready = 1'b1;
    @(posedge clk);
    #1;
    chk("drain tvalid", 32'(sto_tvalid), 32'd0);

    // 2: single stage, two occurrences, post=2
    bus_wr(saddr(0, 0), 32'hA5);
    bus_wr(saddr(0, 1), 32'hFF);
    bus_wr(saddr(0, 2), 32'd2);
    bus_wr(BAW'(2), 32'd0);
    bus_wr(BAW'(1), 32'd2);
    bus_wr(BAW'(0), 32'd1);
    chk("t2 armed state", 32'(sts_state), 32'd1);
    run_table(2);

    // 3: consecutive occurrences required
    bus_wr(saddr(0, 2), (32'd1 << TCW) | 32'd2);
    bus_wr(BAW'(0), 32'd1);
    run_table(3);

    // 4: two stages, post=0
    bus_wr(saddr(0, 0), 32'h01);
    bus_wr(saddr(0, 2), 32'd0);
    bus_wr(saddr(1, 0), 32'h02);
    bus_wr(saddr(1, 1), 32'hFF);
    bus_wr(saddr(1, 2), 32'd0);
    bus_wr(BAW'(2), 32'd1);
    bus_wr(BAW'(1), 32'd0);
    bus_wr(BAW'(0), 32'd1);
    run_table(4);

    // 5: backpressure during POST
    bus_wr(saddr(0, 0), 32'hA5);
    bus_wr(saddr(0, 2), 32'd1);
    bus_wr(BAW'(2), 32'd0);
    bus_wr(BAW'(1), 32'd3);
    bus_wr(BAW'(0), 32'd1);
    send(32'hA5);
    chk("t5 trig event", 32'(sto_tevent), 32'b10);
    chk("t5 post state", 32'(sts_state), 32'd2);
    @(negedge clk);
    sto_tready = 1'b0;
    sti_tvalid = 1'b1;
    sti_tdata  = 32'h55;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("t5 hold%0d sti_tready", c), 32'(sti_tready), 32'd0);
      chk($sformatf("t5 hold%0d tvalid", c), 32'(sto_tvalid), 32'd1);
      chk($sformatf("t5 hold%0d tdata", c), sto_tdata, 32'hA5);
      chk($sformatf("t5 hold%0d tevent", c), 32'(sto_tevent), 32'b10);
    end
    @(negedge clk);
    sto_tready = 1'b1;
    @(posedge clk);
    #1;
    sti_tvalid = 1'b0;
    chk("t5 release tdata", sto_tdata, 32'h55);
    chk("t5 release tevent", 32'(sto_tevent), 32'b00);
    send(32'h66);
    chk("t5 next tdata", sto_tdata, 32'h66);
    chk("t5 next tevent", 32'(sto_tevent), 32'b00);
    send(32'h77);
    chk("t5 end tdata", sto_tdata, 32'h77);
    chk("t5 end tevent", 32'(sto_tevent), 32'b11);
    chk("t5 done state", 32'(sts_state), 32'd3);

    // 6: arm+abort together, then arm with immediate trigger
    bus_wr(BAW'(0), 32'd3);
    chk("t6 abort state", 32'(sts_state), 32'd0);
    send(32'h10);
    chk("t6 idle tevent", 32'(sto_tevent), 32'b00);
    chk("t6 idle state", 32'(sts_state), 32'd0);
    bus_wr(saddr(0, 0), 32'h10);
    bus_wr(BAW'(1), 32'd1);
    bus_wr(BAW'(0), 32'd1);
    chk("t6 armed state", 32'(sts_state), 32'd1);
    send(32'h10);
    chk("t6 first trig tevent", 32'(sto_tevent), 32'b10);
    chk("t6 first trig state", 32'(sts_state), 32'd2);
    bus_wr(BAW'(0), 32'd2);
    chk("t6 abort from post", 32'(sts_state), 32'd0);

    // writes to a stage beyond TSN must not alias onto stage 0
    bus_wr(saddr(4, 0), 32'h99);
    bus_wr(BAW'(1), 32'd0);
    bus_wr(BAW'(0), 32'd1);
    send(32'h99);
    chk("t7 oob stage tevent", 32'(sto_tevent), 32'b01);
    send(32'h10);
    chk("t7 stage0 trig tevent", 32'(sto_tevent), 32'b10);
    chk("t7 done state", 32'(sts_state), 32'd3);

    // synchronous reset mid-operation
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst2 state", 32'(sts_state), 32'd0);
    chk("rst2 tvalid", 32'(sto_tvalid), 32'd0);
    chk("rst2 tdata", sto_tdata, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
